// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the SPI front end of the AES offload path.
// The optional parity bit is enabled by defining SPI_RESP_PARITY_EN.
package aes_spi_pkg;

  localparam int BLOCK_BITS = 128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    MARK  = 3'd4,
    SEND  = 3'd5,
    PAR   = 3'd6,
    DONE  = 3'd7
  } state_e;

  // Inbound frame: one plaintext block followed by Nk key words.
  function automatic int frame_len(input int nk);
    return BLOCK_BITS + nk * 32;
  endfunction

endpackage

// File: rtl/spi_resp_shifter.sv
// Width-parameterised load/shift register; left shift with sin entering bit 0.
// Load wins over shift when both are requested.
module spi_resp_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift) begin
      q_d = {q_q[W-2:0], sin};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/spi_aes_responder.sv
// SPI target that collects plaintext+key, runs one AES operation through a
// start/done handshake and returns marker + result on SDO (parity: SPI_RESP_PARITY_EN).
module spi_aes_responder
  import aes_spi_pkg::*;
#(
  parameter int Nk = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               CS,
  input  logic               SDI,
  output logic               SDO,
  output logic               core_start,
  output logic [127:0]       core_data,
  output logic [Nk*32-1:0]   core_key,
  input  logic               core_done,
  input  logic [127:0]       core_result,
  output logic               frame_done,
  output logic [2:0]         dbg_state
);

  localparam int L  = frame_len(Nk);
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] LAST_RX  = CW'(L);
  localparam logic [CW-1:0] LAST_TX  = CW'(BLOCK_BITS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Handshake: core_start is a one-cycle request; core_done is a one-cycle
  // reply carrying core_result, honoured only while waiting for it.
  state_e          state_d, state_q;
  logic [CW-1:0]   cnt_d, cnt_q;
  logic            sdo_d, sdo_q;
  logic            rx_shift, tx_load, tx_shift;
  logic [L-1:0]    rx_q;
  logic [127:0]    tx_q;
  logic            unused_tx;

`ifdef SPI_RESP_PARITY_EN
  logic par_d, par_q;
`endif

  spi_resp_shifter #(.W(L)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ('0),
    .shift    (rx_shift),
    .sin      (SDI),
    .q        (rx_q)
  );

  spi_resp_shifter #(.W(BLOCK_BITS)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (tx_load),
    .load_val (core_result),
    .shift    (tx_shift),
    .sin      (1'b0),
    .q        (tx_q)
  );

  assign unused_tx = ^tx_q[126:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sdo_d    = 1'b0;
    rx_shift = 1'b0;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    case (state_q)
      IDLE: if (!CS) begin
        rx_shift = 1'b1;
        cnt_d    = CNT_ONE;
        state_d  = RECV;
      end
      RECV: if (CS) begin
        state_d = IDLE;
      end else begin
        rx_shift = 1'b1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q + CNT_ONE == LAST_RX) state_d = START;
      end
      START: state_d = CS ? IDLE : WAIT;
      WAIT: if (CS) begin
        state_d = IDLE;
      end else if (core_done) begin
        tx_load = 1'b1;
        sdo_d   = 1'b1;
        state_d = MARK;
      end
      MARK: if (CS) begin
        state_d = IDLE;
      end else begin
        sdo_d    = tx_q[127];
        tx_shift = 1'b1;
        cnt_d    = CNT_ONE;
        state_d  = SEND;
      end
      // cnt counts result bits already placed on SDO.
      SEND: if (CS) begin
        state_d = IDLE;
      end else if (cnt_q == LAST_TX) begin
`ifdef SPI_RESP_PARITY_EN
        sdo_d   = par_q;
        state_d = PAR;
`else
        state_d = DONE;
`endif
      end else begin
        sdo_d    = tx_q[127];
        tx_shift = 1'b1;
        cnt_d    = cnt_q + CNT_ONE;
      end
`ifdef SPI_RESP_PARITY_EN
      PAR: state_d = CS ? IDLE : DONE;
`endif
      DONE: if (CS) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef SPI_RESP_PARITY_EN
  assign par_d = tx_load ? ~^core_result : par_q;

  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sdo_q   <= sdo_d;
    end
  end

  assign SDO        = sdo_q;
  assign core_start = (state_q == START) && !CS;
  assign frame_done = (state_q == DONE);
  assign core_data  = rx_q[L-1 -: BLOCK_BITS];
  assign core_key   = rx_q[Nk*32-1:0];
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_aes_responder.sv
// Directed bench: Nk=4 and Nk=8 responders driven by a hand-sequenced mock core.
module tb_spi_aes_responder;

  logic         clk;
  logic         rst;
  logic         cs_a   [2];
  logic         sdi_a  [2];
  logic         sdo_a  [2];
  logic         start_a[2];
  logic [127:0] data_a [2];
  logic         done_a [2];
  logic [127:0] res_a  [2];
  logic         fdone_a[2];
  logic [2:0]   dbg_a  [2];
  logic [127:0] key4;
  logic [255:0] key8;

  int total = 0;
  int bad   = 0;
  int n_start[2];
  int n_sdo1 [2];

  spi_aes_responder #(.Nk(4)) dut4 (
    .clk(clk), .rst(rst), .CS(cs_a[0]), .SDI(sdi_a[0]), .SDO(sdo_a[0]),
    .core_start(start_a[0]), .core_data(data_a[0]), .core_key(key4),
    .core_done(done_a[0]), .core_result(res_a[0]), .frame_done(fdone_a[0]),
    .dbg_state(dbg_a[0])
  );

  spi_aes_responder #(.Nk(8)) dut8 (
    .clk(clk), .rst(rst), .CS(cs_a[1]), .SDI(sdi_a[1]), .SDO(sdo_a[1]),
    .core_start(start_a[1]), .core_data(data_a[1]), .core_key(key8),
    .core_done(done_a[1]), .core_result(res_a[1]), .frame_done(fdone_a[1]),
    .dbg_state(dbg_a[1])
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (start_a[i] === 1'b1) n_start[i]++;
      if (sdo_a[i] === 1'b1)   n_sdo1[i]++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Shifts n bits MSB first; returns one ns after the edge sampling the last bit.
  task automatic send_bits(input int sel, input logic [383:0] bits, input int n);
    n_start[sel] = 0;
    for (int i = n - 1; i >= 0; i--) begin
      cs_a[sel]  = 1'b0;
      sdi_a[sel] = bits[i];
      step();
    end
    sdi_a[sel] = 1'b0;
  endtask

  // Mock core: done after lat cycles, then checks marker, result, parity, frame_done.
  task automatic respond(input int sel, input logic [127:0] res, input int lat, input string tag);
    logic [127:0] got;
    repeat (lat) step();
    done_a[sel] = 1'b1;
    res_a[sel]  = res;
    step();
    done_a[sel] = 1'b0;
    res_a[sel]  = '0;
    chk({tag, "_marker"}, 256'(sdo_a[sel]), 256'(1));
    for (int i = 127; i >= 0; i--) begin
      step();
      got[i] = sdo_a[sel];
    end
    chk({tag, "_result"}, 256'(got), 256'(res));
    step();
`ifdef SPI_RESP_PARITY_EN
    chk({tag, "_parity"}, 256'(fdone_a[sel]), 256'(0));
    chk({tag, "_parbit"}, 256'(sdo_a[sel]), 256'(~^res));
    step();
`endif
    chk({tag, "_fdone"}, 256'(fdone_a[sel]), 256'(1));
    chk({tag, "_sdo_done"}, 256'(sdo_a[sel]), 256'(0));
    chk({tag, "_nstart"}, 256'(n_start[sel]), 256'(1));
    cs_a[sel] = 1'b1;
    step();
    chk({tag, "_fdone_clr"}, 256'(fdone_a[sel]), 256'(0));
  endtask

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT8  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT2  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] K2   = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] CT2  = 128'hdeadbeef0badf00dcafef00d12345678;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cs_a[i] = 1'b1; sdi_a[i] = 1'b0; done_a[i] = 1'b0; res_a[i] = '0;
      n_start[i] = 0; n_sdo1[i] = 0;
    end
    step(); step();
    chk("rst_sdo", 256'(sdo_a[0]), 256'(0));
    chk("rst_start", 256'(start_a[0]), 256'(0));
    chk("rst_fdone", 256'(fdone_a[0]), 256'(0));
    chk("rst_data", 256'(data_a[0]), 256'(0));
    chk("rst_key8", key8, 256'(0));
    chk("rst_state", 256'(dbg_a[1]), 256'(0));
    rst = 1'b0;
    step();

    // FIPS-197 AES-128 vector
    send_bits(0, {128'h0, PT, K128}, 256);
    chk("fips_start257", 256'(start_a[0]), 256'(1));
    chk("fips_data", 256'(data_a[0]), 256'(PT));
    chk("fips_key", 256'(key4), 256'(K128));
    respond(0, CT4, 10, "fips");
    chk("fips_data_hold", 256'(data_a[0]), 256'(PT));

    // Nk=8 frame
    send_bits(1, {PT, K256}, 384);
    chk("nk8_start385", 256'(start_a[1]), 256'(1));
    chk("nk8_data", 256'(data_a[1]), 256'(PT));
    chk("nk8_key", key8, K256);
    respond(1, CT8, 3, "nk8");

    // Abort after 100 bits, then a late core_done
    n_sdo1[0] = 0;
    send_bits(0, {128'h0, PT2, K2}, 100);
    cs_a[0] = 1'b1;
    step();
    chk("abort_state", 256'(dbg_a[0]), 256'(0));
    step();
    done_a[0] = 1'b1; res_a[0] = CT2;
    step();
    done_a[0] = 1'b0; res_a[0] = '0;
    repeat (3) step();
    chk("abort_nstart", 256'(n_start[0]), 256'(0));
    chk("abort_sdo", 256'(n_sdo1[0]), 256'(0));
    chk("abort_fdone", 256'(fdone_a[0]), 256'(0));
    send_bits(0, {128'h0, PT2, K2}, 256);
    chk("after_abort_data", 256'(data_a[0]), 256'(PT2));
    chk("after_abort_key", 256'(key4), 256'(K2));
    respond(0, CT2, 1, "after_abort");

    // Reset in the middle of the result
    send_bits(0, {128'h0, PT, K128}, 256);
    repeat (2) step();
    done_a[0] = 1'b1; res_a[0] = 128'hffffffffffffffffffffffffffffffff;
    step();
    done_a[0] = 1'b0; res_a[0] = '0;
    repeat (40) step();
    chk("mid_send_sdo", 256'(sdo_a[0]), 256'(1));
    rst = 1'b1;
    step();
    chk("rst_send_sdo", 256'(sdo_a[0]), 256'(0));
    chk("rst_send_fdone", 256'(fdone_a[0]), 256'(0));
    chk("rst_send_data", 256'(data_a[0]), 256'(0));
    rst = 1'b0; cs_a[0] = 1'b1; n_sdo1[0] = 0; n_start[0] = 0;
    step();
    done_a[0] = 1'b1; res_a[0] = CT4;
    step();
    done_a[0] = 1'b0; res_a[0] = '0;
    repeat (3) step();
    chk("late_done_sdo", 256'(n_sdo1[0]), 256'(0));
    chk("late_done_state", 256'(dbg_a[0]), 256'(0));
    chk("late_done_start", 256'(n_start[0]), 256'(0));

    // Parity corner results, sent back to back with one CS-high cycle
    send_bits(0, {128'h0, PT, K128}, 256);
    respond(0, 128'h0, 2, "res_zero");
    send_bits(0, {128'h0, PT2, K2}, 256);
    chk("b2b_data", 256'(data_a[0]), 256'(PT2));
    respond(0, 128'h1, 5, "res_one");
`ifdef SPI_RESP_PARITY_EN
    chk("par_zero_hand", 256'(~^128'h0), 256'(1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
